// File: rtl/write_iq.sv
// rtl/write_iq.sv - IQ sample pair to byte stream serializer (dequantize, narrow, 4 bytes per pair)
//
// Pops one I and one Q sample together from two show-ahead sample FIFOs.
// Each sample is dequantized by an arithmetic right shift of BITS and
// narrowed to CHAR_SIZE bits. Each pair is then written as 4 bytes,
// low byte first, I before Q, into a byte-wide output FIFO.
//
// Optional feature macro: WRITE_IQ_SATURATE_EN
//   defined   : the shifted sample is clamped to the signed CHAR_SIZE range
//   undefined : the low CHAR_SIZE bits of the shifted sample are kept (wrap)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   i_in_empty  in   I sample FIFO empty
//   q_in_empty  in   Q sample FIFO empty
//   in_rd_en    out  shared pop strobe for the I and Q FIFOs
//   i_in        in   signed I sample (show-ahead FIFO data)
//   q_in        in   signed Q sample (show-ahead FIFO data)
//   out_full    in   output byte FIFO full
//   out_wr_en   out  output byte write strobe
//   data_out    out  output byte
//   busy        out  high while a held pair has not been fully sent

module write_iq #(
    parameter int DATA_SIZE = 32,
    parameter int CHAR_SIZE = 16,
    parameter int BYTE      = 8,
    parameter int BITS      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_in_empty,
    input  logic                 q_in_empty,
    output logic                 in_rd_en,
    input  logic [DATA_SIZE-1:0] i_in,
    input  logic [DATA_SIZE-1:0] q_in,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [BYTE-1:0]      data_out,
    output logic                 busy
);

    typedef enum logic {
        READ = 1'b0,
        SEND = 1'b1
    } state_t;

`ifdef WRITE_IQ_SATURATE_EN
    localparam logic signed [DATA_SIZE-1:0] SAT_MAX =
        DATA_SIZE'((64'sd1 <<< (CHAR_SIZE - 1)) - 64'sd1);
    localparam logic signed [DATA_SIZE-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    // Dequantize (floor toward -inf via arithmetic shift) and narrow.
    function automatic logic [CHAR_SIZE-1:0] convert(input logic [DATA_SIZE-1:0] x);
`ifdef WRITE_IQ_SATURATE_EN
        logic signed [DATA_SIZE-1:0] s;
        s = $signed(x) >>> BITS;
        if (s > SAT_MAX) begin
            return SAT_MAX[CHAR_SIZE-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[CHAR_SIZE-1:0];
        end else begin
            return s[CHAR_SIZE-1:0];
        end
`else
        return CHAR_SIZE'($signed(x) >>> BITS);
`endif
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [CHAR_SIZE-1:0] i_q, i_d;
    logic [CHAR_SIZE-1:0] q_q, q_d;
    logic                 pop;
    logic                 pair_ready;

    // Both FIFOs must hold data; a lone non-empty FIFO is never popped.
    assign pair_ready = !i_in_empty && !q_in_empty;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= READ;
            idx_q   <= 2'd0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_d     = i_q;
        q_d     = q_q;
        pop     = 1'b0;
        case (state_q)
            READ: begin
                if (pair_ready) begin
                    pop     = 1'b1;
                    i_d     = convert(i_in);
                    q_d     = convert(q_in);
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!out_full) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        // Chain straight into the next pair so there is no idle cycle.
                        if (pair_ready) begin
                            pop = 1'b1;
                            i_d = convert(i_in);
                            q_d = convert(q_in);
                        end else begin
                            state_d = READ;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = READ;
        endcase
    end

    // Output logic; the pop strobe is masked while reset is held so a
    // non-empty FIFO cannot be drained during reset.
    always_comb begin
        in_rd_en  = pop && !reset;
        busy      = (state_q == SEND);
        out_wr_en = (state_q == SEND) && !out_full;
        data_out  = '0;
        if (state_q == SEND) begin
            case (idx_q)
                2'd0:    data_out = i_q[BYTE-1:0];
                2'd1:    data_out = i_q[2*BYTE-1:BYTE];
                2'd2:    data_out = q_q[BYTE-1:0];
                default: data_out = q_q[2*BYTE-1:BYTE];
            endcase
        end
    end

endmodule

// File: tb/tb_write_iq.sv
// tb/tb_write_iq.sv - self-checking bench for write_iq with input FIFO model and byte scoreboard

module tb_write_iq;

    logic        clock;
    logic        reset;
    logic        i_in_empty;
    logic        q_in_empty;
    logic        in_rd_en;
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic        out_full;
    logic        out_wr_en;
    logic [7:0]  data_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] i_fifo[$];
    logic [31:0] q_fifo[$];
    logic [7:0]  exp_q[$];
    logic        rd_seen = 1'b0;
    logic        q_force_empty = 1'b0;

    write_iq dut (
        .clock      (clock),
        .reset      (reset),
        .i_in_empty (i_in_empty),
        .q_in_empty (q_in_empty),
        .in_rd_en   (in_rd_en),
        .i_in       (i_in),
        .q_in       (q_in),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .data_out   (data_out),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference dequantizer: floor division by 1024, then clamp or wrap to 16 bits.
    function automatic logic [15:0] model(input logic [31:0] x);
        longint v;
        longint f;
        v = longint'($signed(x));
        f = (v >= 0) ? (v / 1024) : -((-v + 1023) / 1024);
`ifdef WRITE_IQ_SATURATE_EN
        if (f > 32767) f = 32767;
        if (f < -32768) f = -32768;
`endif
        return f[15:0];
    endfunction

    task automatic push_pair(input logic [31:0] iv, input logic [31:0] qv);
        logic [15:0] ci;
        logic [15:0] cq;
        ci = model(iv);
        cq = model(qv);
        i_fifo.push_back(iv);
        q_fifo.push_back(qv);
        exp_q.push_back(ci[7:0]);
        exp_q.push_back(ci[15:8]);
        exp_q.push_back(cq[7:0]);
        exp_q.push_back(cq[15:8]);
    endtask

    // Show-ahead input FIFO model; updated after every rising edge.
    always @(posedge clock) begin
        #2;
        if (rd_seen) begin
            if (i_fifo.size() == 0 || q_fifo.size() == 0) begin
                errors++;
                $display("FAIL fifo_pop_when_empty: in_rd_en=1 with isz=%0d qsz=%0d, required no pop",
                         i_fifo.size(), q_fifo.size());
            end else begin
                void'(i_fifo.pop_front());
                void'(q_fifo.pop_front());
            end
            rd_seen = 1'b0;
        end
        i_in_empty = (i_fifo.size() == 0);
        q_in_empty = (q_fifo.size() == 0) || q_force_empty;
        i_in = (i_fifo.size() != 0) ? i_fifo[0] : 32'h0;
        q_in = (q_fifo.size() != 0) ? q_fifo[0] : 32'h0;
    end

    // Output scoreboard monitor.
    always @(negedge clock) begin
        if (in_rd_en === 1'b1) rd_seen = 1'b1;
        if (out_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected: got %02h, required no write", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL byte_value: got %02h, required %02h", data_out, e);
                end
            end
        end
    end

    task automatic wait_pop(output bit found);
        int n;
        n = 0;
        @(negedge clock);
        while (in_rd_en !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        found = (in_rd_en === 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_full = 1'b0;
        #1;
        checks++;
        if ({in_rd_en, out_wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: rd/wr/busy=%b, required 000", {in_rd_en, out_wr_en, busy});
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %02h, required 00", data_out);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({in_rd_en, out_wr_en, busy, data_out} !== 11'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rd/wr/busy/data=%b, required 0", {in_rd_en, out_wr_en, busy, data_out});
        end
    endtask

    task automatic test_basic();
        bit found;
        @(posedge clock); #1;
        push_pair(32'h0000_1400, 32'hFFFF_FC00);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL basic_pop: no in_rd_en, required a pop");
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (out_wr_en !== 1'b1 || in_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL basic_write%0d: wr=%b rd=%b, required wr=1 rd=0", k, out_wr_en, in_rd_en);
            end
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || out_wr_en !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL basic_idle: busy=%b wr=%b data=%02h, required 0 0 00", busy, out_wr_en, data_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic test_saturate();
        @(posedge clock); #1;
        push_pair(32'h7FFF_FFFF, 32'h8000_0000);
        push_pair(32'hFFFF_FBFF, 32'h0000_03FF);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL saturate_drain: %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit found;
        logic [7:0] held;
        @(posedge clock); #1;
        push_pair(32'h0000_0400, 32'h0000_0800);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_pop: no in_rd_en, required a pop");
        end
        repeat (2) @(negedge clock);
        @(posedge clock); #1 out_full = 1'b1;
        held = exp_q[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (out_wr_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d: wr=%b busy=%b, required wr=0 busy=1", k, out_wr_en, busy);
            end
            checks++;
            if (data_out !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: data=%02h, required %02h", k, data_out, held);
            end
        end
        @(posedge clock); #1 out_full = 1'b0;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        @(posedge clock); #1;
        push_pair(32'h0001_2345, 32'hFFFE_0000);
        push_pair(32'h0000_0C00, 32'hFFFF_F800);
        push_pair(32'h0123_4567, 32'hFEDC_BA98);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_pop: no in_rd_en, required a pop");
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checks++;
            if (out_wr_en !== 1'b1) begin
                errors++;
                $display("FAIL b2b_write%0d: wr=%b, required 1", k, out_wr_en);
            end
            checks++;
            if (in_rd_en !== ((k == 3) || (k == 7))) begin
                errors++;
                $display("FAIL b2b_pop%0d: rd=%b, required %b", k, in_rd_en, (k == 3) || (k == 7));
            end
        end
        @(negedge clock);
        checks++;
        if (out_wr_en !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: wr=%b busy=%b left=%0d, required 0 0 0", out_wr_en, busy, exp_q.size());
        end
    endtask

    task automatic test_one_empty();
        @(posedge clock); #1;
        q_force_empty = 1'b1;
        push_pair(32'hFFFF_0000, 32'h0000_5000);
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if (in_rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL one_empty%0d: rd=%b busy=%b, required 0 0", k, in_rd_en, busy);
            end
        end
        @(posedge clock); #1 q_force_empty = 1'b0;
        @(negedge clock);
        checks++;
        if (in_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL one_empty_release: rd=%b, required 1", in_rd_en);
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL one_empty_drain: %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        @(posedge clock); #1;
        push_pair(32'h0000_2800, 32'h0000_3C00);
        push_pair(32'hFFFF_E000, 32'h0004_0400);
        wait_pop(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rmid_pop: no in_rd_en, required a pop");
        end
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        #1;
        checks++;
        if ({in_rd_en, out_wr_en, busy, data_out} !== 11'b0) begin
            errors++;
            $display("FAIL rmid_outputs: rd/wr/busy/data=%b, required 0", {in_rd_en, out_wr_en, busy, data_out});
        end
        // The two unsent bytes of the interrupted pair are discarded.
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(posedge clock); #1 reset = 1'b0;
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || i_fifo.size() != 0) begin
            errors++;
            $display("FAIL rmid_drain: bytes left=%0d fifo=%0d, required 0 0", exp_q.size(), i_fifo.size());
        end
    endtask

    initial begin
        i_in_empty = 1'b1;
        q_in_empty = 1'b1;
        i_in = 32'h0;
        q_in = 32'h0;
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_one_empty();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
